// File: rtl/lru_feeder.sv
// Transmit side of the LRU buffer valid_data/data link: FIFO of pushed words replayed as
// HOLD_CYC-wide valid_data pulses separated by at least GAP_CYC low cycles. Optional LRU_FEEDER_DEDUP_EN.
module lru_feeder #(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = 1,
    parameter int GAP_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data,
    output logic             valid_data,
    output logic             busy,
    output logic [7:0]       sent_count
`ifdef LRU_FEEDER_DEDUP_EN
    ,
    output logic [7:0]       dup_count
`endif
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CNTW-1:0]  count;
    logic             push_ok, pop;
    logic [WIDTH-1:0] head;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] data_n;
    logic             vld_n, launch, is_dup;
    logic [7:0]       sent_n;
`ifdef LRU_FEEDER_DEDUP_EN
    logic [7:0]       dup_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            data       <= '0;
            valid_data <= 1'b0;
            sent_count <= 8'd0;
`ifdef LRU_FEEDER_DEDUP_EN
            dup_count  <= 8'd0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            data       <= data_n;
            valid_data <= vld_n;
            sent_count <= sent_n;
`ifdef LRU_FEEDER_DEDUP_EN
            dup_count  <= dup_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = data;
        vld_n   = valid_data;
        sent_n  = sent_count;
        pop     = 1'b0;
        launch  = 1'b0;
`ifdef LRU_FEEDER_DEDUP_EN
        dup_n   = dup_count;
        is_dup  = (head == data) && (sent_count != 8'd0);
`else
        is_dup  = 1'b0;
`endif
        case (state)
            IDLE: begin
                vld_n  = 1'b0;
                launch = !empty;
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    vld_n   = 1'b0;
                    cnt_n   = CW'(GAP_CYC - 1);
                    state_n = GAP;
                end
            end
            GAP: begin
                if (cnt != '0)  cnt_n   = cnt - CW'(1);
                else if (!empty) launch = 1'b1;
                else            state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (launch) begin
            pop = 1'b1;
            if (is_dup) begin
                // Repeat of the word already on the bus: drop it silently, re-arbitrate from IDLE.
                vld_n   = 1'b0;
                state_n = IDLE;
`ifdef LRU_FEEDER_DEDUP_EN
                dup_n   = dup_count + 8'd1;
`endif
            end else begin
                data_n  = head;
                vld_n   = 1'b1;
                cnt_n   = CW'(HOLD_CYC - 1);
                state_n = HOLD;
                sent_n  = sent_count + 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_lru_feeder.sv
// Directed bench for lru_feeder: three instances (default, 3/2 timing, long hold) share stimulus.
module tb_lru_feeder;

    logic        clk, rst, push;
    logic [11:0] push_data;

    logic        full0, empty0, vld0, busy0;
    logic [11:0] data0;
    logic [7:0]  sent0;
    logic        full1, empty1, vld1, busy1;
    logic [11:0] data1;
    logic [7:0]  sent1;
    logic        full2, empty2, vld2, busy2;
    logic [11:0] data2;
    logic [7:0]  sent2;
`ifdef LRU_FEEDER_DEDUP_EN
    logic [7:0]  dup0, dup1, dup2;
`endif

    int tests = 0;
    int fails = 0;

    lru_feeder u0 (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .full(full0), .empty(empty0), .data(data0), .valid_data(vld0),
        .busy(busy0), .sent_count(sent0)
`ifdef LRU_FEEDER_DEDUP_EN
        , .dup_count(dup0)
`endif
    );

    lru_feeder #(.HOLD_CYC(3), .GAP_CYC(2)) u1 (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .full(full1), .empty(empty1), .data(data1), .valid_data(vld1),
        .busy(busy1), .sent_count(sent1)
`ifdef LRU_FEEDER_DEDUP_EN
        , .dup_count(dup1)
`endif
    );

    lru_feeder #(.HOLD_CYC(20), .GAP_CYC(1)) u2 (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .full(full2), .empty(empty2), .data(data2), .valid_data(vld2),
        .busy(busy2), .sent_count(sent2)
`ifdef LRU_FEEDER_DEDUP_EN
        , .dup_count(dup2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 1'b0; push_data = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (empty0 !== 1'b1) begin fails++; $display("FAIL rst_empty got %b exp 1", empty0); end
        tests++; if (full0 !== 1'b0) begin fails++; $display("FAIL rst_full got %b exp 0", full0); end
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy0); end
        tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", vld0); end
        tests++; if (data0 !== 12'h000) begin fails++; $display("FAIL rst_data got %h exp 000", data0); end
        tests++; if (sent0 !== 8'd0) begin fails++; $display("FAIL rst_sent got %0d exp 0", sent0); end
    endtask

    task automatic test_latency();
        do_reset();
        push = 1'b1; push_data = 12'h0A5;
        tick();
        push = 1'b0;
        tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL lat_early got %b exp 0", vld0); end
        tick();
        tests++; if (vld0 !== 1'b1) begin fails++; $display("FAIL lat_valid got %b exp 1", vld0); end
        tests++; if (data0 !== 12'h0A5) begin fails++; $display("FAIL lat_data got %h exp 0a5", data0); end
        tick();
        tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL lat_fall got %b exp 0", vld0); end
        tests++; if (data0 !== 12'h0A5) begin fails++; $display("FAIL lat_data_hold got %h exp 0a5", data0); end
        tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL lat_busy_gap got %b exp 1", busy0); end
        tick();
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL lat_busy_idle got %b exp 0", busy0); end
        tests++; if (sent0 !== 8'd1) begin fails++; $display("FAIL lat_sent got %0d exp 1", sent0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vmask;
        logic [11:0] d [8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push = (i < 3);
            push_data = 12'(i + 1);
            tick();
            vmask[i] = vld0;
            d[i] = data0;
        end
        push = 1'b0;
        tests++; if (vmask !== 8'b0010_1010) begin fails++; $display("FAIL b2b_pattern got %b exp 00101010", vmask); end
        tests++; if (d[1] !== 12'h001) begin fails++; $display("FAIL b2b_word0 got %h exp 001", d[1]); end
        tests++; if (d[2] !== 12'h001) begin fails++; $display("FAIL b2b_gap_hold got %h exp 001", d[2]); end
        tests++; if (d[3] !== 12'h002) begin fails++; $display("FAIL b2b_word1 got %h exp 002", d[3]); end
        tests++; if (d[5] !== 12'h003) begin fails++; $display("FAIL b2b_word2 got %h exp 003", d[5]); end
        tests++; if (sent0 !== 8'd3) begin fails++; $display("FAIL b2b_sent got %0d exp 3", sent0); end
    endtask

    task automatic test_hold_gap();
        logic [11:0] words [4];
        logic        exp_v;
        logic [11:0] exp_d;
        int          bad_v, bad_d;
        words[0] = 12'hA11; words[1] = 12'hB22; words[2] = 12'hC33; words[3] = 12'hD44;
        bad_v = 0; bad_d = 0;
        do_reset();
        // Launches land at edges 2,7,12,17: 3 high, 2 low, period 5.
        for (int k = 1; k <= 24; k++) begin
            push = (k <= 4);
            push_data = words[(k - 1) % 4];
            tick();
            exp_v = (k >= 2) && (k < 20) && (((k - 2) % 5) < 3);
            exp_d = (k >= 2) ? words[((k - 2) / 5) % 4] : 12'h000;
            if (vld1 !== exp_v) bad_v++;
            if (exp_v && data1 !== exp_d) bad_d++;
        end
        push = 1'b0;
        tests++; if (bad_v !== 0) begin fails++; $display("FAIL hg_valid_shape got %0d bad cycles exp 0", bad_v); end
        tests++; if (bad_d !== 0) begin fails++; $display("FAIL hg_data got %0d bad cycles exp 0", bad_d); end
        tests++; if (sent1 !== 8'd4) begin fails++; $display("FAIL hg_sent got %0d exp 4", sent1); end
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL hg_idle got %b exp 0", busy1); end
    endtask

    task automatic test_full();
        logic [11:0] caps [16];
        int          n;
        logic        prev;
        do_reset();
        push = 1'b1; push_data = 12'h100;
        tick();
        push = 1'b0;
        tick();
        // u2 now holds its pulse for 20 cycles, so the FIFO only fills.
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; push_data = 12'h200 + 12'(i);
            tick();
            if (i == 6) begin
                tests++; if (full2 !== 1'b0) begin fails++; $display("FAIL full_7th got %b exp 0", full2); end
            end
            if (i == 7) begin
                tests++; if (full2 !== 1'b1) begin fails++; $display("FAIL full_8th got %b exp 1", full2); end
            end
        end
        push = 1'b0;
        tests++; if (full2 !== 1'b1) begin fails++; $display("FAIL full_after_drop got %b exp 1", full2); end
        n = 0; prev = vld2;
        for (int c = 0; c < 260; c++) begin
            tick();
            if (vld2 && !prev && n < 16) begin caps[n] = data2; n++; end
            prev = vld2;
        end
        tests++; if (n !== 8) begin fails++; $display("FAIL full_pulses got %0d exp 8", n); end
        for (int i = 0; i < 8 && i < n; i++) begin
            tests++; if (caps[i] !== 12'h200 + 12'(i)) begin fails++; $display("FAIL full_word%0d got %h exp %h", i, caps[i], 12'h200 + 12'(i)); end
        end
        tests++; if (empty2 !== 1'b1) begin fails++; $display("FAIL full_end_empty got %b exp 1", empty2); end
        tests++; if (sent2 !== 8'd9) begin fails++; $display("FAIL full_sent got %0d exp 9", sent2); end
    endtask

    task automatic test_reset_mid();
        int stray;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = 12'h300 + 12'(i);
            tick();
        end
        push = 1'b0;
        tests++; if (vld1 !== 1'b1) begin fails++; $display("FAIL rm_in_hold got %b exp 1", vld1); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (vld1 !== 1'b0) begin fails++; $display("FAIL rm_valid got %b exp 0", vld1); end
        tests++; if (data1 !== 12'h000) begin fails++; $display("FAIL rm_data got %h exp 000", data1); end
        tests++; if (empty1 !== 1'b1) begin fails++; $display("FAIL rm_empty got %b exp 1", empty1); end
        tests++; if (sent1 !== 8'd0) begin fails++; $display("FAIL rm_sent got %0d exp 0", sent1); end
        stray = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (vld1 !== 1'b0) stray++;
        end
        tests++; if (stray !== 0) begin fails++; $display("FAIL rm_no_pulses got %0d exp 0", stray); end
    endtask

`ifdef LRU_FEEDER_DEDUP_EN
    task automatic test_dedup();
        logic [11:0] caps [8];
        logic [11:0] seq [3];
        int          n;
        logic        prev;
        seq[0] = 12'h7FF; seq[1] = 12'h7FF; seq[2] = 12'h123;
        do_reset();
        n = 0; prev = 1'b0;
        for (int c = 0; c < 14; c++) begin
            push = (c < 3);
            push_data = seq[c % 3];
            tick();
            if (vld0 && !prev && n < 8) begin caps[n] = data0; n++; end
            prev = vld0;
        end
        push = 1'b0;
        tests++; if (n !== 2) begin fails++; $display("FAIL dd_pulses got %0d exp 2", n); end
        tests++; if (n > 0 && caps[0] !== 12'h7FF) begin fails++; $display("FAIL dd_word0 got %h exp 7ff", caps[0]); end
        tests++; if (n > 1 && caps[1] !== 12'h123) begin fails++; $display("FAIL dd_word1 got %h exp 123", caps[1]); end
        tests++; if (dup0 !== 8'd1) begin fails++; $display("FAIL dd_dup got %0d exp 1", dup0); end
        tests++; if (sent0 !== 8'd2) begin fails++; $display("FAIL dd_sent got %0d exp 2", sent0); end
    endtask
`endif

    initial begin
        rst = 1'b1; push = 1'b0; push_data = '0;
        test_reset();
`ifndef LRU_FEEDER_DEDUP_EN
        test_latency();
        test_back_to_back();
        test_hold_gap();
        test_full();
`else
        test_latency();
        test_dedup();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
